// File: rtl/inst_queue.sv
// In-order {inst,pc} queue between fetch and dispatch; one push and one pop per cycle, entry poppable one edge after its push.
// IF_full asserts at DEPTH-1 so one in-flight push always fits; DP_ready gates pops, rdy freezes all state.
module inst_queue #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int INST_W = 32,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              IF_S,
    input  logic [INST_W-1:0] IF_Inst,
    input  logic [PC_W-1:0]   IF_pc,
    output logic              IF_full,
    input  logic              DP_ready,
    output logic              DP_S,
    output logic [INST_W-1:0] DP_Inst,
    output logic [PC_W-1:0]   DP_pc,
    input  logic              ROB_Jump_S
);

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } entry_t;

    localparam logic [ADDR_W:0] CNT_MAX  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH - 1);

    entry_t              mem_q [DEPTH];
    logic [ADDR_W-1:0]   head_q, head_d;
    logic [ADDR_W-1:0]   tail_q, tail_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                dp_s_q, dp_s_d;
    entry_t              dp_dat_q, dp_dat_d;
    logic                push, pop;
    logic                wr_en;
    entry_t              wr_dat;

    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        dp_s_d   = 1'b0;
        dp_dat_d = dp_dat_q;
        push     = IF_S && (count_q < CNT_MAX);
        pop      = DP_ready && (count_q != '0);
        wr_en    = 1'b0;
        wr_dat   = '{inst: IF_Inst, pc: IF_pc};

        if (ROB_Jump_S) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (rdy) begin
            if (push) begin
                wr_en  = 1'b1;
                tail_d = tail_q + ADDR_W'(1);
            end
            if (pop) begin
                dp_s_d   = 1'b1;
                dp_dat_d = mem_q[head_q];
                head_d   = head_q + ADDR_W'(1);
            end
            // count is sampled pre-edge, so a push never feeds a same-cycle pop
            if (push && !pop) begin
                count_d = count_q + (ADDR_W+1)'(1);
            end else if (pop && !push) begin
                count_d = count_q - (ADDR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            dp_s_q   <= 1'b0;
            dp_dat_q <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            dp_s_q   <= dp_s_d;
            dp_dat_q <= dp_dat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[tail_q] <= wr_dat;
        end
    end

    assign IF_full = (count_q >= CNT_FULL);
    assign DP_S    = dp_s_q;
    assign DP_Inst = dp_dat_q.inst;
    assign DP_pc   = dp_dat_q.pc;

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: reset, fill/drain, wrap, flush, stall and async reset.
module tb_inst_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        IF_S;
    logic [31:0] IF_Inst;
    logic [31:0] IF_pc;
    logic        IF_full;
    logic        DP_ready;
    logic        DP_S;
    logic [31:0] DP_Inst;
    logic [31:0] DP_pc;
    logic        ROB_Jump_S;

    int check_cnt = 0;
    int error_cnt = 0;

    inst_queue #(.DEPTH(16), .ADDR_W(4), .INST_W(32), .PC_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .IF_S       (IF_S),
        .IF_Inst    (IF_Inst),
        .IF_pc      (IF_pc),
        .IF_full    (IF_full),
        .DP_ready   (DP_ready),
        .DP_S       (DP_S),
        .DP_Inst    (DP_Inst),
        .DP_pc      (DP_pc),
        .ROB_Jump_S (ROB_Jump_S)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_cnt++;
        if (got !== exp) begin
            error_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_only(input logic [31:0] pc, input logic [31:0] inst);
        IF_S = 1'b1; IF_pc = pc; IF_Inst = inst;
        tick();
        IF_S = 1'b0;
    endtask

    // A push landing on a full queue is a protocol error and must never be driven.
    always @(negedge clk) begin
        if (rst && rdy && !ROB_Jump_S && IF_S)
            chk("no_overflow", {63'd0, dut.count_q == 5'd16}, 64'd0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; rdy = 1'b1; IF_S = 1'b1; IF_Inst = 32'h0; IF_pc = 32'h0;
        DP_ready = 1'b1; ROB_Jump_S = 1'b0;

        // 1: reset with IF_S high, then first push/pop latency
        tick(); tick();
        chk("rst_dp_s", {63'd0, DP_S}, 64'd0);
        chk("rst_full", {63'd0, IF_full}, 64'd0);
        chk("rst_pc", {32'd0, DP_pc}, 64'd0);
        chk("rst_inst", {32'd0, DP_Inst}, 64'd0);
        IF_S = 1'b0;
        rst = 1'b1;
        tick();
        push_only(32'h0, 32'h0000_0513);
        chk("t1_no_bypass", {63'd0, DP_S}, 64'd0);
        tick();
        chk("t1_dp_s", {63'd0, DP_S}, 64'd1);
        chk("t1_pc", {32'd0, DP_pc}, 64'h0);
        chk("t1_inst", {32'd0, DP_Inst}, 64'h0000_0513);
        tick();
        chk("t1_pulse_end", {63'd0, DP_S}, 64'd0);

        // 2: fill to 16 with dispatch stalled, then drain
        DP_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            push_only(32'(4 * i), 32'h1000_0000 + 32'(i));
            chk("t2_full_fill", {63'd0, IF_full}, {63'd0, (i + 1) >= 15});
        end
        DP_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            tick();
            chk("t2_dp_s", {63'd0, DP_S}, 64'd1);
            chk("t2_pc", {32'd0, DP_pc}, 64'(4 * j));
            chk("t2_inst", {32'd0, DP_Inst}, 64'h1000_0000 + 64'(j));
            chk("t2_full_drain", {63'd0, IF_full}, {63'd0, (15 - j) >= 15});
        end
        tick();
        chk("t2_empty", {63'd0, DP_S}, 64'd0);

        // 3: steady push+pop, pointers wrap twice
        for (int i = 0; i <= 40; i++) begin
            IF_S = (i < 40); IF_pc = 32'h200 + 32'(4 * i); IF_Inst = 32'hA000_0000 + 32'(i);
            tick();
            if (i > 0) begin
                chk("t3_dp_s", {63'd0, DP_S}, 64'd1);
                chk("t3_pc", {32'd0, DP_pc}, 64'h200 + 64'(4 * (i - 1)));
            end
            chk("t3_full", {63'd0, IF_full}, 64'd0);
        end
        IF_S = 1'b0;
        tick();
        chk("t3_drained", {63'd0, DP_S}, 64'd0);

        // 4: flush with a same-cycle push
        DP_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_only(32'h300 + 32'(4 * i), 32'hB000_0000 + 32'(i));
        ROB_Jump_S = 1'b1; IF_S = 1'b1; IF_pc = 32'h999; DP_ready = 1'b1;
        tick();
        ROB_Jump_S = 1'b0; IF_S = 1'b0;
        chk("t4_flush_dp_s", {63'd0, DP_S}, 64'd0);
        chk("t4_flush_full", {63'd0, IF_full}, 64'd0);
        tick();
        chk("t4_empty", {63'd0, DP_S}, 64'd0);
        push_only(32'h100, 32'hC000_0000);
        tick();
        chk("t4_dp_s", {63'd0, DP_S}, 64'd1);
        chk("t4_pc", {32'd0, DP_pc}, 64'h100);

        // 5: rdy low freezes everything
        DP_ready = 1'b0;
        push_only(32'h400, 32'hD000_0000);
        push_only(32'h404, 32'hD000_0001);
        rdy = 1'b0; IF_S = 1'b1; IF_pc = 32'h888; DP_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_stall_dp_s", {63'd0, DP_S}, 64'd0);
            chk("t5_stall_pc", {32'd0, DP_pc}, 64'h100);
        end
        rdy = 1'b1; IF_S = 1'b0;
        tick();
        chk("t5_resume_dp_s", {63'd0, DP_S}, 64'd1);
        chk("t5_resume_pc", {32'd0, DP_pc}, 64'h400);
        tick();
        chk("t5_second_pc", {32'd0, DP_pc}, 64'h404);
        tick();
        chk("t5_empty", {63'd0, DP_S}, 64'd0);

        // 6: async reset mid-cycle with entries queued
        DP_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_only(32'h500 + 32'(4 * i), 32'hE000_0000 + 32'(i));
        DP_ready = 1'b1;
        tick();
        chk("t6_pre_dp_s", {63'd0, DP_S}, 64'd1);
        chk("t6_pre_pc", {32'd0, DP_pc}, 64'h500);
        #2 rst = 1'b0;
        #1;
        chk("t6_async_dp_s", {63'd0, DP_S}, 64'd0);
        chk("t6_async_pc", {32'd0, DP_pc}, 64'd0);
        chk("t6_async_inst", {32'd0, DP_Inst}, 64'd0);
        chk("t6_async_full", {63'd0, IF_full}, 64'd0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_post_empty", {63'd0, DP_S}, 64'd0);
        end
        push_only(32'h600, 32'hF000_0000);
        tick();
        chk("t6_new_dp_s", {63'd0, DP_S}, 64'd1);
        chk("t6_new_pc", {32'd0, DP_pc}, 64'h600);

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
        $finish;
    end

endmodule
